// File: rtl/cga_mac_apos_icagen.sv
// cga_mac_apos_icagen: cache address sequencer feeding the MAC address-position latch.
module cga_mac_apos_icagen #(
    parameter int WIDTH     = 16,
    parameter int PAGE_BITS = 10,
    parameter int LEN_BITS  = 4
) (
    input  logic                MCLK,
    input  logic                RESET_N,
    input  logic                LDA,
    input  logic [WIDTH-1:0]    ADDR_15_0,
    input  logic                START,
    input  logic [LEN_BITS-1:0] BLEN,
    input  logic                HOLD,
    input  logic                ABORT,
    input  logic                WRAP_EN,
    output logic [WIDTH-1:0]    ICA_15_0,
    output logic                BUSY,
    output logic                DONE,
    output logic                PAGEX
);
    localparam logic IDLE  = 1'b0;
    localparam logic BURST = 1'b1;
    logic                      state;
    logic [LEN_BITS-1:0]       cnt;
    logic                      carry;
    logic [PAGE_BITS-1:0]      lowNext;
    logic [WIDTH-PAGE_BITS-1:0] highNext;
    always_comb begin
        carry    = &ICA_15_0[PAGE_BITS-1:0];
        lowNext  = ICA_15_0[PAGE_BITS-1:0] + PAGE_BITS'(1);
        highNext = ICA_15_0[WIDTH-1:PAGE_BITS] + (WIDTH-PAGE_BITS)'(carry & ~WRAP_EN);
    end
    assign BUSY = state;
    // BUSY comes straight from the state flop, so every output stays registered
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= IDLE;
            cnt      <= '0;
            ICA_15_0 <= '0;
            DONE     <= 1'b0;
            PAGEX    <= 1'b0;
        end else begin
            DONE  <= 1'b0;
            PAGEX <= 1'b0;
            if (state == IDLE) begin
                if (LDA) ICA_15_0 <= ADDR_15_0;
                if (START) begin
                    cnt   <= BLEN;
                    state <= BURST;
                end
            end else if (ABORT) begin
                state <= IDLE;
            end else if (!HOLD) begin
                if (cnt == '0) begin
                    state <= IDLE;
                    DONE  <= 1'b1;
                end else begin
                    ICA_15_0 <= {highNext, lowNext};
                    cnt      <= cnt - LEN_BITS'(1);
                    PAGEX    <= carry;
                end
            end
        end
    end
endmodule

// File: tb/tb_cga_mac_apos_icagen.sv
// tb_cga_mac_apos_icagen: directed and randomized checks of the address sequencer against a behavioural model.
module tb_cga_mac_apos_icagen;
    logic        MCLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        LDA = 1'b0;
    logic [15:0] ADDR_15_0 = '0;
    logic        START = 1'b0;
    logic [3:0]  BLEN = '0;
    logic        HOLD = 1'b0;
    logic        ABORT = 1'b0;
    logic        WRAP_EN = 1'b0;
    logic [15:0] ICA_15_0;
    logic        BUSY, DONE, PAGEX;
    int checks = 0;
    int failures = 0;

    cga_mac_apos_icagen dut (
        .MCLK(MCLK), .RESET_N(RESET_N), .LDA(LDA), .ADDR_15_0(ADDR_15_0),
        .START(START), .BLEN(BLEN), .HOLD(HOLD), .ABORT(ABORT), .WRAP_EN(WRAP_EN),
        .ICA_15_0(ICA_15_0), .BUSY(BUSY), .DONE(DONE), .PAGEX(PAGEX)
    );

    always #5 MCLK = ~MCLK;

    function automatic int nextAddr(input int a, input bit w);
        return w ? ((a & 'hFC00) | ((a + 1) & 'h3FF)) : ((a + 1) & 'hFFFF);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: address as an integer, burst tracked as beats still to present.
    int mIca = 0;
    bit mBusy = 0, mDone = 0, mPagex = 0;
    int beatsLeft = 0;
    always @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            mIca <= 0; mBusy <= 0; mDone <= 0; mPagex <= 0; beatsLeft <= 0;
        end else begin
            mDone <= 0;
            mPagex <= 0;
            if (!mBusy) begin
                if (LDA) mIca <= int'(ADDR_15_0);
                if (START) begin
                    mBusy <= 1;
                    beatsLeft <= int'(BLEN);
                end
            end else if (ABORT) begin
                mBusy <= 0;
            end else if (!HOLD) begin
                if (beatsLeft == 0) begin
                    mBusy <= 0;
                    mDone <= 1;
                end else begin
                    mIca <= nextAddr(mIca, WRAP_EN);
                    mPagex <= (mIca % 1024) == 1023;
                    beatsLeft <= beatsLeft - 1;
                end
            end
        end
    end

    always @(negedge MCLK) begin
        chk("model_ica", 32'(ICA_15_0), 32'(mIca));
        chk("model_busy", 32'(BUSY), 32'(mBusy));
        chk("model_done", 32'(DONE), 32'(mDone));
        chk("model_pagex", 32'(PAGEX), 32'(mPagex));
    end

    task automatic cyc();
        @(posedge MCLK);
        #1;
    endtask

    task automatic expect4(input string nm, input logic [15:0] ica, input logic b, input logic d, input logic p);
        chk({nm, "_ica"}, 32'(ICA_15_0), 32'(ica));
        chk({nm, "_busy"}, 32'(BUSY), 32'(b));
        chk({nm, "_done"}, 32'(DONE), 32'(d));
        chk({nm, "_pagex"}, 32'(PAGEX), 32'(p));
    endtask

    task automatic burst(input logic [15:0] a, input logic [3:0] n, input logic w);
        LDA = 1; ADDR_15_0 = a; START = 1; BLEN = n; WRAP_EN = w;
        cyc();
        LDA = 0; START = 0;
    endtask

    initial begin
        repeat (3) cyc();
        RESET_N = 1;
        cyc();
        expect4("rst_idle", 16'h0000, 0, 0, 0);

        burst(16'h1234, 3, 0);
        expect4("basic0", 16'h1234, 1, 0, 0);
        cyc(); expect4("basic1", 16'h1235, 1, 0, 0);
        cyc(); expect4("basic2", 16'h1236, 1, 0, 0);
        cyc(); expect4("basic3", 16'h1237, 1, 0, 0);
        cyc(); expect4("basic_done", 16'h1237, 0, 1, 0);
        cyc(); expect4("basic_after", 16'h1237, 0, 0, 0);

        burst(16'h07FE, 3, 1);
        expect4("wrap0", 16'h07FE, 1, 0, 0);
        cyc(); expect4("wrap1", 16'h07FF, 1, 0, 0);
        cyc(); expect4("wrap2", 16'h0400, 1, 0, 1);
        cyc(); expect4("wrap3", 16'h0401, 1, 0, 0);
        cyc(); expect4("wrap_done", 16'h0401, 0, 1, 0);

        burst(16'h07FE, 3, 0);
        cyc(); cyc(); expect4("carry2", 16'h0800, 1, 0, 1);
        cyc(); expect4("carry3", 16'h0801, 1, 0, 0);
        cyc(); expect4("carry_done", 16'h0801, 0, 1, 0);

        burst(16'h0010, 2, 0);
        expect4("stall0", 16'h0010, 1, 0, 0);
        cyc(); expect4("stall1", 16'h0011, 1, 0, 0);
        HOLD = 1;
        cyc(); expect4("stall2", 16'h0011, 1, 0, 0);
        cyc(); expect4("stall3", 16'h0011, 1, 0, 0);
        HOLD = 0;
        cyc(); expect4("stall4", 16'h0012, 1, 0, 0);
        cyc(); expect4("stall_done", 16'h0012, 0, 1, 0);

        burst(16'h0100, 7, 0);
        cyc(); cyc(); expect4("abort_pre", 16'h0102, 1, 0, 0);
        ABORT = 1; HOLD = 1;
        cyc(); expect4("abort", 16'h0102, 0, 0, 0);
        ABORT = 0; HOLD = 0;
        burst(16'h2000, 0, 0);
        expect4("single", 16'h2000, 1, 0, 0);
        cyc(); expect4("single_done", 16'h2000, 0, 1, 0);

        burst(16'h3000, 2, 0);
        LDA = 1; ADDR_15_0 = 16'hAAAA;
        cyc(); expect4("ign1", 16'h3001, 1, 0, 0);
        cyc(); expect4("ign2", 16'h3002, 1, 0, 0);
        LDA = 0;
        cyc(); expect4("ign_done", 16'h3002, 0, 1, 0);

        burst(16'hFFFF, 1, 0);
        expect4("top0", 16'hFFFF, 1, 0, 0);
        cyc(); expect4("top1", 16'h0000, 1, 0, 1);
        cyc(); expect4("top_done", 16'h0000, 0, 1, 0);

        burst(16'h0123, 5, 0);
        #2 RESET_N = 0;
        #1 expect4("async_rst", 16'h0000, 0, 0, 0);
        cyc();
        #1 RESET_N = 1;
        cyc();
        START = 1; BLEN = 1;
        cyc(); START = 0;
        expect4("post_rst", 16'h0000, 1, 0, 0);
        cyc(); expect4("post_rst1", 16'h0001, 1, 0, 0);
        cyc(); expect4("post_rst_done", 16'h0001, 0, 1, 0);

        for (int i = 0; i < 4000; i++) begin
            LDA = ($urandom_range(3) == 0);
            ADDR_15_0 = ($urandom_range(1) == 0) ? 16'($urandom) : {6'($urandom), 10'h3FC + 10'($urandom_range(3))};
            START = ($urandom_range(2) == 0);
            BLEN = 4'($urandom);
            HOLD = ($urandom_range(4) == 0);
            ABORT = ($urandom_range(15) == 0);
            WRAP_EN = 1'($urandom);
            RESET_N = ($urandom_range(199) != 0);
            cyc();
        end
        RESET_N = 1; LDA = 0; START = 0; HOLD = 0; ABORT = 0;
        repeat (20) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
